// File: rtl/sl_preceptron_pkg.sv
// Shared types and sizing for the serial perceptron neuron: FSM states, accumulator width, default geometry.
package sl_preceptron_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int VEC_LEN_DEF    = 48;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DRAIN = 3'd2,
        ST_BIAS  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Full-precision sum of VEC_LEN signed DATA_WIDTH x DATA_WIDTH products.
    function automatic int acc_w(input int dw, input int vl);
        return 2 * dw + $clog2(vl);
    endfunction

endpackage

// File: rtl/sl_preceptron_mac.sv
// Registered signed multiply-accumulate; clear wins over enable, one product folded in per enabled cycle.
module sl_preceptron_mac #(
    parameter int DW = 8,
    parameter int AW = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [AW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_q;

    assign prod = a * b;
    assign acc  = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + AW'(prod);
        end
    end

endmodule

// File: rtl/sl_preceptron_ctrl.sv
// Serial perceptron controller: fetches one weight per element, accumulates, adds bias, activates.
// Activation is step by default; define SL_PRECEPTRON_RELU_EN for saturated ReLU (same timing).
module sl_preceptron_ctrl
    import sl_preceptron_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int VEC_LEN    = VEC_LEN_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  w_rd_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  err_overrun,
    input  logic                  err_clr
);

    localparam int ACC_W = acc_w(DATA_WIDTH, VEC_LEN);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LEN - 1);

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   w_addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    mac_en_q;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    err_q;

    logic                    accept;
    logic                    drop;
    logic                    mac_clr;
    logic                    handshake;
    logic signed [ACC_W-1:0] acc;
    logic signed [SUM_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = (LAST_IDX == '0) ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (in_valid && idx_q == LAST_IDX) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_BIAS;
            ST_BIAS:  state_d = ST_OUT;
            ST_OUT:   if (result_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Elements seen during reset are neither accepted nor flagged.
    always_comb begin
        accept       = 1'b0;
        drop         = 1'b0;
        mac_clr      = 1'b0;
        handshake    = 1'b0;
        busy         = (state_q != ST_IDLE);
        result_valid = (state_q == ST_OUT);
        case (state_q)
            ST_IDLE:  begin
                accept  = in_valid && !rst;
                mac_clr = in_valid && !rst;
            end
            ST_ACCUM: accept = in_valid && !rst;
            ST_OUT:   begin
                drop      = in_valid && !rst;
                handshake = result_ready;
            end
            default:  drop = in_valid && !rst;
        endcase
        w_rd_en = accept;
        w_addr  = accept ? idx_q : w_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            w_addr_q <= '0;
            data_q   <= '0;
            mac_en_q <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            mac_en_q <= accept;
            if (accept) begin
                data_q   <= in_data;
                w_addr_q <= idx_q;
                idx_q    <= idx_q + 1'b1;
            end else if (handshake) begin
                idx_q <= '0;
            end
            if (state_q == ST_BIAS) begin
                result_q <= result_d;
            end
            if (drop) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Product of element k lands one cycle after its acceptance, when the weight returns.
    sl_preceptron_mac #(
        .DW (DATA_WIDTH),
        .AW (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en_q),
        .a   ($signed(data_q)),
        .b   ($signed(w_data)),
        .acc (acc)
    );

    assign sum = SUM_W'(acc) + SUM_W'($signed(bias));

`ifdef SL_PRECEPTRON_RELU_EN
    localparam logic signed [SUM_W-1:0] RELU_MAX = SUM_W'((1 <<< (DATA_WIDTH - 1)) - 1);

    always_comb begin
        if (sum < 0) begin
            result_d = '0;
        end else if (sum > RELU_MAX) begin
            result_d = RELU_MAX[DATA_WIDTH-1:0];
        end else begin
            result_d = sum[DATA_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        result_d = {{(DATA_WIDTH-1){1'b0}}, ~sum[SUM_W-1]};
    end
`endif

    assign result      = result_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_sl_preceptron_ctrl.sv
// Directed bench for sl_preceptron_ctrl at VEC_LEN=4, DATA_WIDTH=8 with a 1-cycle weight memory model.
module tb_sl_preceptron_ctrl;

    localparam int DW = 8;
    localparam int VL = 4;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] w_addr;
    logic          w_rd_en;
    logic [DW-1:0] w_data;
    logic [DW-1:0] bias;
    logic          result_valid;
    logic          result_ready;
    logic [DW-1:0] result;
    logic          busy;
    logic          err_overrun;
    logic          err_clr;

    int n_chk;
    int n_fail;

    logic [DW-1:0] wmem [0:(1<<AW)-1];

    typedef struct packed {
        logic [7:0]      gap;
        logic [3:0][7:0] x;
        logic [3:0][7:0] w;
        logic [7:0]      b;
        logic [7:0]      exp_step;
        logic [7:0]      exp_relu;
    } vec_t;

    vec_t tbl [0:6];

    sl_preceptron_ctrl #(
        .DATA_WIDTH (DW),
        .VEC_LEN    (VL),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .w_addr       (w_addr),
        .w_rd_en      (w_rd_en),
        .w_data       (w_data),
        .bias         (bias),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy),
        .err_overrun  (err_overrun),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_data <= wmem[w_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int g, input int x0, input int x1, input int x2, input int x3,
                                input int w0, input int w1, input int w2, input int w3,
                                input int b, input int es, input int er);
        vec_t v;
        v.gap = 8'(g);
        v.x[0] = 8'(x0); v.x[1] = 8'(x1); v.x[2] = 8'(x2); v.x[3] = 8'(x3);
        v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
        v.b = 8'(b);
        v.exp_step = 8'(es);
        v.exp_relu = 8'(er);
        return v;
    endfunction

    function automatic int exp_of(input vec_t v);
`ifdef SL_PRECEPTRON_RELU_EN
        return int'(v.exp_relu);
`else
        return int'(v.exp_step);
`endif
    endfunction

    // Entered just after a rising edge; returns at the falling edge of the first OUT cycle.
    task automatic run_vec(input vec_t v, input string tag);
        int cnt;
        for (int i = 0; i < VL; i++) wmem[i] = v.w[i];
        bias = v.b;
        for (int i = 0; i < VL; i++) begin
            in_valid = 1'b1;
            in_data  = v.x[i];
            @(negedge clk);
            chk($sformatf("%s rd_en e%0d", tag, i), int'(w_rd_en), 1);
            chk($sformatf("%s addr e%0d", tag, i), int'(w_addr), i);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < VL - 1) begin
                for (int g = 0; g < int'(v.gap); g++) begin
                    @(negedge clk);
                    chk($sformatf("%s gap rd_en", tag), int'(w_rd_en), 0);
                    chk($sformatf("%s gap addr hold", tag), int'(w_addr), i);
                    chk($sformatf("%s gap busy", tag), int'(busy), 1);
                    @(posedge clk); #1;
                end
            end
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!result_valid && cnt < 10);
        chk($sformatf("%s latency", tag), cnt, 3);
        chk($sformatf("%s result", tag), int'(result), exp_of(v));
    endtask

    // Entered at a falling edge in OUT; returns just after a rising edge in IDLE.
    task automatic handshake(input string tag);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("%s post valid", tag), int'(result_valid), 0);
        chk($sformatf("%s post busy", tag), int'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        clk = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        bias = '0;
        result_ready = 1'b0;
        err_clr = 1'b0;
        w_data = '0;
        for (int i = 0; i < (1 << AW); i++) wmem[i] = '0;

        tbl[0] = mk(0,    1,    2,    3,    4,   1,   1,   1,   1,  -10, 1,   0);
        tbl[1] = mk(0, -128, -128, -128, -128, 127, 127, 127, 127, -128, 0,   0);
        tbl[2] = mk(0,  100,  100,  100,  100, 100, 100, 100, 100,    0, 1, 127);
        tbl[3] = mk(3,    1,    2,    3,    4,   1,   1,   1,   1,  -10, 1,   0);
        tbl[4] = mk(1,    5,    6,    7,    8,   1,   2,  -1,   1,    2, 1,  20);
        tbl[5] = mk(0,   10,   20,   30,   40,  -1,  -1,  -1,  -1,   99, 0,   0);
        tbl[6] = mk(2,   -5,    0,    0,    0,   1,   1,   1,   1,  127, 1, 122);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(result_valid), 0);
        chk("reset result", int'(result), 0);
        chk("reset rd_en", int'(w_rd_en), 0);
        chk("reset addr", int'(w_addr), 0);
        chk("reset err", int'(err_overrun), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
            handshake($sformatf("v%0d", i));
        end

        // Stalled output with overrun pulses, then set-beats-clear.
        run_vec(tbl[4], "hold");
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 1 || k == 3);
            in_data = 8'h55;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("hold valid", int'(result_valid), 1);
            chk("hold result", int'(result), exp_of(tbl[4]));
            chk("hold rd_en", int'(w_rd_en), 0);
        end
        chk("overrun set", int'(err_overrun), 1);
        in_valid = 1'b1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        chk("overrun set over clr", int'(err_overrun), 1);
        handshake("hold");
        run_vec(tbl[0], "after_hold");
        handshake("after_hold");
        chk("overrun sticky", int'(err_overrun), 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("overrun cleared", int'(err_overrun), 0);
        @(posedge clk); #1;

        // Abort mid-vector with reset; element coincident with reset is ignored.
        for (int i = 0; i < VL; i++) wmem[i] = 8'sd50;
        in_data = 8'sd100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort busy", int'(busy), 0);
        chk("abort valid", int'(result_valid), 0);
        chk("abort result", int'(result), 0);
        chk("abort rd_en", int'(w_rd_en), 0);
        chk("abort addr", int'(w_addr), 0);
        chk("abort err", int'(err_overrun), 0);
        @(posedge clk); #1;
        run_vec(mk(0, 1, 1, 1, 1, 2, 2, 2, 2, 0, 1, 8), "post_abort");
        handshake("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
